// File: rtl/mmio_bus_pkg.sv
// Shared types and default constants for the MMIO bus router.
// Holds the router FSM state encoding and the default region map.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_N_SLV = 3;

  localparam logic [DEF_N_SLV*16-1:0] DEF_SLV_BASE =
    {16'h3000, 16'h2000, 16'h1000};

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational priority decoder of the top 16 address bits
// against the per-slave region bases; lowest index wins.
module mmio_addr_decode
  import mmio_bus_pkg::*;
#(
  parameter int N_SLV  = DEF_N_SLV,
  parameter int ADDR_W = 32,
  parameter logic [N_SLV*16-1:0] SLV_BASE = DEF_SLV_BASE
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  hit,
  output logic              miss
);

  logic unused_low;
  assign unused_low = ^addr[ADDR_W-17:0];

  // Scan high to low so the lowest matching index is the last write.
  always_comb begin
    hit = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (addr[ADDR_W-1 -: 16] == SLV_BASE[i*16 +: 16]) begin
        hit = N_SLV'(1) << i;
      end
    end
  end

  assign miss = ~|hit;

endmodule

// File: rtl/mmio_bus_router.sv
// Registered CPU-to-peripheral MMIO router, one transaction at a time.
// Optional access timeout enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_router
  import mmio_bus_pkg::*;
#(
  parameter int N_SLV       = DEF_N_SLV,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [N_SLV*16-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic [DATA_W/8-1:0]     cpu_wstrb,
  output logic                    cpu_ready,
  output logic                    cpu_rvalid,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_err,
  output logic [N_SLV-1:0]        slv_sel,
  output logic                    slv_we,
  output logic [ADDR_W-1:0]       slv_addr,
  output logic [DATA_W-1:0]       slv_wdata,
  output logic [DATA_W/8-1:0]     slv_wstrb,
  input  logic [N_SLV*DATA_W-1:0] slv_rdata,
  input  logic [N_SLV-1:0]        slv_ack
);

  state_t            state;
  logic [N_SLV-1:0]  hit;
  logic              miss;
  logic              sel_ack;
  logic [DATA_W-1:0] sel_rdata;
  logic              tmo;

  mmio_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE)
  ) u_dec (
    .addr (cpu_addr),
    .hit  (hit),
    .miss (miss)
  );

  assign sel_ack = |(slv_ack & slv_sel);

  // Read data of the currently selected slave only.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (slv_sel[i]) begin
        sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt;

  assign tmo = (cnt == TMO_LAST);

  // Count ACCESS cycles; cleared whenever the router leaves ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ACCESS && !sel_ack && !tmo) begin
      cnt <= cnt + 16'd1;
    end else begin
      cnt <= '0;
    end
  end
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;

  assign tmo = 1'b0;
`endif

  // Router FSM with all CPU and slave outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cpu_ready  <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      slv_sel    <= '0;
      slv_we     <= 1'b0;
      slv_addr   <= '0;
      slv_wdata  <= '0;
      slv_wstrb  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_ready <= 1'b0;
            slv_addr  <= cpu_addr;
            slv_wdata <= cpu_wdata;
            slv_wstrb <= cpu_wstrb;
            if (miss) begin
              state      <= RESP;
              cpu_rvalid <= 1'b1;
              cpu_err    <= 1'b1;
              cpu_rdata  <= ERR_DATA;
            end else begin
              state   <= ACCESS;
              slv_sel <= hit;
              slv_we  <= cpu_we;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            state      <= RESP;
            slv_sel    <= '0;
            slv_we     <= 1'b0;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b0;
            cpu_rdata  <= slv_we ? '0 : sel_rdata;
          end else if (tmo) begin
            state      <= RESP;
            slv_sel    <= '0;
            slv_we     <= 1'b0;
            cpu_rvalid <= 1'b1;
            cpu_err    <= 1'b1;
            cpu_rdata  <= ERR_DATA;
          end
        end
        RESP: begin
          state     <= IDLE;
          cpu_ready <= 1'b1;
          cpu_err   <= 1'b0;
          cpu_rdata <= '0;
        end
        default: begin
          state     <= IDLE;
          cpu_ready <= 1'b1;
          slv_sel   <= '0;
          slv_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
